label_str_loader: RTL and testbench

//  Runtime writer for the 16-entry x 8-char label table that the rect/ASCII overlay reads.

---
 rtl/label_str_loader_pkg.sv | 12 +
 rtl/label_frame_parser.sv | 61 ++++++
 rtl/label_str_loader.sv | 37 +++
 tb/tb_label_str_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/label_str_loader_pkg.sv
// label_str_loader_pkg: shared sizes, sync marker, parser states and the power-on label table.
// Optional inter-byte timeout is enabled by defining LABEL_LOADER_TIMEOUT_EN.
package label_str_loader_pkg;
   localparam int N_LABEL = 16;
   localparam int N_CHAR = 8;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int TO_CYC_DEF = 2700000;
   localparam logic [N_LABEL*N_CHAR*8-1:0] LBL_DEFAULT = {
      "        ", "Pie     ", "Pesi    ", "7xi     ", "44444444", "55555555", "Tang    ", "Kang    ",
      "Choc    ", "Coca    ", "AAAAAAAA", "BBBBBBBB", "CCCCCCCC", "DDDDDDDD", "EEEEEEEE", "FFFFFFFF"};
   typedef enum logic [1:0] {S_IDLE, S_IDX, S_CHR, S_CHK} state_t;
endpackage

// File: rtl/label_frame_parser.sv
// label_frame_parser: frame FSM, running XOR checksum and staging buffer for one label entry.
module label_frame_parser
  import label_str_loader_pkg::*;
#(parameter int TO_CYC = TO_CYC_DEF)
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        commit,
  output logic        err,
  output logic        busy,
  output logic [3:0]  idx,
  output logic [63:0] entry
);
  state_t state;
  logic [7:0] chk;
  logic [2:0] cnt;
  logic [7:0] chars_q [N_CHAR];
  logic to_hit;
`ifdef LABEL_LOADER_TIMEOUT_EN
  logic [31:0] tcnt;
  assign to_hit = !i_rx_valid && state != S_IDLE && tcnt == 32'(TO_CYC - 1);
  always_ff @(posedge i_clk)
    tcnt <= (!i_rst_n || i_rx_valid || state == S_IDLE) ? '0 : tcnt + 32'd1;
`else
  assign to_hit = 1'b0;
`endif
  assign commit = i_rx_valid && state == S_CHK && i_rx_data == chk;
  assign err = to_hit || (i_rx_valid && ((state == S_IDX && |i_rx_data[7:4]) ||
                                         (state == S_CHK && i_rx_data != chk)));
  assign busy = state != S_IDLE;
  always_comb
    for (int i = 0; i < N_CHAR; i++) entry[63-8*i -: 8] = chars_q[i];
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state <= S_IDLE;
      chk <= '0;
      cnt <= '0;
      idx <= '0;
    end else if (to_hit) state <= S_IDLE;
    else if (i_rx_valid)
      case (state)
        S_IDLE: state <= (i_rx_data == SYNC_BYTE) ? S_IDX : S_IDLE;
        S_IDX:
          if (|i_rx_data[7:4]) state <= S_IDLE;
          else begin
            idx <= i_rx_data[3:0];
            chk <= i_rx_data;
            cnt <= '0;
            state <= S_CHR;
          end
        S_CHR: begin
          chars_q[cnt] <= i_rx_data;
          chk <= chk ^ i_rx_data;
          cnt <= cnt + 3'd1;
          state <= (cnt == 3'd7) ? S_CHK : S_CHR;
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: rtl/label_str_loader.sv
// label_str_loader: byte-stream writer for the packed 16x8-char overlay label table.
module label_str_loader
  import label_str_loader_pkg::*;
#(parameter int TO_CYC = TO_CYC_DEF)
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic [1023:0] o_str,
  output logic          o_update,
  output logic [3:0]    o_upd_idx,
  output logic          o_err,
  output logic          o_busy
);
  logic commit, err;
  logic [3:0] idx;
  logic [63:0] entry;
  label_frame_parser #(.TO_CYC(TO_CYC)) u_parser (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .commit(commit), .err(err), .busy(o_busy), .idx(idx), .entry(entry)
  );
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      o_str <= LBL_DEFAULT;
      o_update <= 1'b0;
      o_err <= 1'b0;
      o_upd_idx <= '0;
    end else begin
      o_update <= commit;
      o_err <= err;
      if (commit) begin
        o_str[{~idx, 6'b0} +: 64] <= entry;
        o_upd_idx <= idx;
      end
    end
endmodule

// File: tb/tb_label_str_loader.sv
// tb_label_str_loader: directed and randomized frames checked against a per-entry label table model.
module tb_label_str_loader;
  logic i_clk = 0, i_rst_n = 0, i_rx_valid = 0;
  logic [7:0] i_rx_data = '0;
  logic [1023:0] o_str;
  logic o_update, o_err, o_busy;
  logic [3:0] o_upd_idx;
  int vectors = 0, miscompares = 0, gap_max = 0;
  logic [63:0] exp_tbl [16];
  logic [3:0] last_idx;
  logic [1023:0] def_tbl = {
    "        ", "Pie     ", "Pesi    ", "7xi     ", "44444444", "55555555", "Tang    ", "Kang    ",
    "Choc    ", "Coca    ", "AAAAAAAA", "BBBBBBBB", "CCCCCCCC", "DDDDDDDD", "EEEEEEEE", "FFFFFFFF"};
  always #5 i_clk = ~i_clk;
  label_str_loader #(.TO_CYC(100)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_str(o_str), .o_update(o_update), .o_upd_idx(o_upd_idx), .o_err(o_err), .o_busy(o_busy)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic check_table(input string tag);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_entry%0d", tag, k), o_str[(15-k)*64 +: 64], exp_tbl[k]);
  endtask
  task automatic model_reset();
    for (int k = 0; k < 16; k++) exp_tbl[k] = def_tbl[(15-k)*64 +: 64];
    last_idx = '0;
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(gap_max)) tick();
    i_rx_data = b;
    i_rx_valid = 1;
    tick();
    i_rx_valid = 0;
  endtask
  task automatic do_reset();
    i_rst_n = 0;
    tick();
    i_rst_n = 1;
    model_reset();
  endtask
  task automatic send_frame(input logic [7:0] idx, input logic [63:0] txt, input logic [7:0] flip);
    logic [7:0] c = idx;
    bit good;
    send(8'hA5);
    check("busy_after_sync", 64'(o_busy), 64'd1);
    send(idx);
    if (idx[7:4] != 0) begin
      check("err_bad_idx", 64'(o_err), 64'd1);
      check("busy_after_bad_idx", 64'(o_busy), 64'd0);
      return;
    end
    check("err_on_idx", 64'(o_err), 64'd0);
    for (int i = 0; i < 8; i++) begin
      c ^= txt[63-8*i -: 8];
      send(txt[63-8*i -: 8]);
      check("no_update_mid_frame", 64'(o_update), 64'd0);
    end
    send(c ^ flip);
    good = (flip == 0);
    if (good) begin
      exp_tbl[idx[3:0]] = txt;
      last_idx = idx[3:0];
    end
    check("update_pulse", 64'(o_update), 64'(good));
    check("err_pulse", 64'(o_err), 64'(!good));
    check("upd_idx", 64'(o_upd_idx), 64'(last_idx));
    check_table("after_chk");
    tick();
    check("update_clears", 64'(o_update), 64'd0);
    check("err_clears", 64'(o_err), 64'd0);
    check("busy_idle", 64'(o_busy), 64'd0);
  endtask
  initial begin
    logic [63:0] txt;
    logic [7:0] idx, flip;
    model_reset();
    tick();
    do_reset();
    repeat (10) tick();
    check_table("reset");
    check("reset_update", 64'(o_update), 64'd0);
    check("reset_err", 64'(o_err), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_upd_idx", 64'(o_upd_idx), 64'd0);
    send_frame(8'h03, "Cola    ", 8'h00);
    send_frame(8'h03, "Cola    ", 8'h01);
    send_frame(8'h10, "xxxxxxxx", 8'h00);
    send_frame(8'h0F, {8{8'hA5}}, 8'h00);
    send_frame(8'h00, "first   ", 8'h00);
    send_frame(8'h00, "second  ", 8'h00);
    send(8'hA5);
    send(8'h07);
    for (int i = 0; i < 5; i++) send(8'h41 + 8'(i));
    do_reset();
    check_table("mid_frame_reset");
    check("mid_frame_reset_busy", 64'(o_busy), 64'd0);
    send_frame(8'h07, "postrst ", 8'h00);
    gap_max = 2;
    for (int n = 0; n < 40; n++) begin
      send(8'($urandom_range(8'hA4)));
      check("junk_no_err", 64'(o_err), 64'd0);
      check("junk_not_busy", 64'(o_busy), 64'd0);
      idx = ($urandom_range(9) == 0) ? 8'($urandom_range(255, 16)) : 8'($urandom_range(15));
      txt = {$urandom, $urandom};
      if ($urandom_range(3) == 0) txt[63-8*$urandom_range(7) -: 8] = 8'hA5;
      flip = ($urandom_range(4) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      send_frame(idx, txt, flip);
    end
    gap_max = 0;
`ifdef LABEL_LOADER_TIMEOUT_EN
    send(8'hA5);
    send(8'h05);
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i));
    for (int i = 0; i < 99; i++) begin
      tick();
      check("timeout_early", 64'(o_err), 64'd0);
    end
    tick();
    check("timeout_err", 64'(o_err), 64'd1);
    check("timeout_busy", 64'(o_busy), 64'd0);
    check_table("timeout");
    send_frame(8'h05, "afterto ", 8'h00);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
